// File: rtl/aes_stream_ctrl.sv
// Streaming front end for the register-mapped AES core: turns key/block handshakes into
// the core's write / init-next / status-poll / result-read bus sequence.
module aes_stream_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [255:0] key,
    input  logic         key_len,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    input  logic         in_encdec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         cs,
    output logic         we,
    output logic [7:0]   address,
    output logic [31:0]  write_data,
    input  logic [31:0]  read_data,
    input  logic         error,
    output logic         key_loaded,
    output logic         err_bus,
    output logic         err_timeout
);

    // state    | meaning
    // IDLE     | waiting for key or block offer
    // KEY_*    | key words, CONFIG, CTRL.init      BLK_* | block words, CONFIG, CTRL.next
    // WAIT     | two idle bus cycles before polling POLL  | read STATUS until ready or timeout
    // RES_RD   | four result reads                 OUT   | hold result until consumed
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_KEY_WR   = 4'd1;
    localparam logic [3:0] S_KEY_CFG  = 4'd2;
    localparam logic [3:0] S_KEY_INIT = 4'd3;
    localparam logic [3:0] S_BLK_WR   = 4'd4;
    localparam logic [3:0] S_BLK_CFG  = 4'd5;
    localparam logic [3:0] S_BLK_NEXT = 4'd6;
    localparam logic [3:0] S_WAIT     = 4'd7;
    localparam logic [3:0] S_POLL     = 4'd8;
    localparam logic [3:0] S_RES_RD   = 4'd9;
    localparam logic [3:0] S_OUT      = 4'd10;

    localparam int PW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [3:0]    state;
    logic [2:0]    cnt;
    logic [PW-1:0] poll_cnt;
    logic          op_blk;
    logic          live;
    logic [255:0]  key_q;
    logic          key_len_q;
    logic [127:0]  blk_q;
    logic          encdec_q;
    logic [255:0]  key_sh;
    logic [127:0]  blk_sh;

    assign key_ready = (state == S_IDLE) && live;
    assign in_ready  = (state == S_IDLE) && key_loaded && !key_valid;
    assign key_sh    = key_q << {cnt, 5'b0};
    assign blk_sh    = blk_q << {cnt[1:0], 5'b0};

    always_comb begin
        cs         = 1'b0;
        we         = 1'b0;
        address    = 8'h00;
        write_data = 32'h0;
        case (state)
            S_KEY_WR:   begin cs = 1'b1; we = 1'b1; address = {5'b00010, cnt};
                              write_data = key_sh[255:224]; end
            S_KEY_CFG:  begin cs = 1'b1; we = 1'b1; address = 8'h09;
                              write_data = {30'b0, key_len_q, 1'b0}; end
            S_KEY_INIT: begin cs = 1'b1; we = 1'b1; address = 8'h08; write_data = 32'h1; end
            S_BLK_WR:   begin cs = 1'b1; we = 1'b1; address = {6'b001000, cnt[1:0]};
                              write_data = blk_sh[127:96]; end
            S_BLK_CFG:  begin cs = 1'b1; we = 1'b1; address = 8'h09;
                              write_data = {30'b0, key_len_q, encdec_q}; end
            S_BLK_NEXT: begin cs = 1'b1; we = 1'b1; address = 8'h08; write_data = 32'h2; end
            S_POLL:     begin cs = 1'b1; address = 8'h0a; end
            S_RES_RD:   begin cs = 1'b1; address = {6'b001100, cnt[1:0]}; end
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= 3'd0;
            poll_cnt    <= '0;
            op_blk      <= 1'b0;
            live        <= 1'b0;
            key_q       <= '0;
            key_len_q   <= 1'b0;
            blk_q       <= '0;
            encdec_q    <= 1'b0;
            out_block   <= '0;
            out_valid   <= 1'b0;
            key_loaded  <= 1'b0;
            err_bus     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            live <= 1'b1;
            if (cs && error) begin
                err_bus    <= 1'b1;
                key_loaded <= 1'b0;
                cnt        <= 3'd0;
                state      <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (key_ready && key_valid) begin
                            key_q       <= key;
                            key_len_q   <= key_len;
                            key_loaded  <= 1'b0;
                            err_bus     <= 1'b0;
                            err_timeout <= 1'b0;
                            op_blk      <= 1'b0;
                            cnt         <= 3'd0;
                            state       <= S_KEY_WR;
                        end else if (in_ready && in_valid) begin
                            blk_q    <= in_block;
                            encdec_q <= in_encdec;
                            op_blk   <= 1'b1;
                            cnt      <= 3'd0;
                            state    <= S_BLK_WR;
                        end
                    end
                    S_KEY_WR: begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) state <= S_KEY_CFG;
                    end
                    S_KEY_CFG:  state <= S_KEY_INIT;
                    S_KEY_INIT: begin cnt <= 3'd1; state <= S_WAIT; end
                    S_BLK_WR: begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd3) begin cnt <= 3'd0; state <= S_BLK_CFG; end
                    end
                    S_BLK_CFG:  state <= S_BLK_NEXT;
                    S_BLK_NEXT: begin cnt <= 3'd1; state <= S_WAIT; end
                    S_WAIT: begin
                        if (cnt == 3'd0) begin
                            poll_cnt <= PW'(TIMEOUT_CYCLES - 1);
                            state    <= S_POLL;
                        end else begin
                            cnt <= cnt - 3'd1;
                        end
                    end
                    S_POLL: begin
                        if (read_data[0]) begin
                            cnt <= 3'd0;
                            if (op_blk) state <= S_RES_RD;
                            else begin key_loaded <= 1'b1; state <= S_IDLE; end
                        end else if (poll_cnt == '0) begin
                            err_timeout <= 1'b1;
                            key_loaded  <= 1'b0;
                            state       <= S_IDLE;
                        end else begin
                            poll_cnt <= poll_cnt - PW'(1);
                        end
                    end
                    S_RES_RD: begin
                        // RESULT0 is read first, so after four shifts it sits in [127:96]
                        out_block <= {out_block[95:0], read_data};
                        cnt       <= cnt + 3'd1;
                        if (cnt == 3'd3) begin cnt <= 3'd0; state <= S_OUT; end
                    end
                    S_OUT: begin
                        if (!out_valid) out_valid <= 1'b1;
                        else if (out_ready) begin
                            out_valid <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Bench for aes_stream_ctrl: a stub AES core answering from the NIST AES-256 ECB vectors,
// with a scoreboard queue of expected result beats.
module tb_aes_stream_ctrl;
    localparam int TMO = 8;
    localparam logic [255:0] KEY =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] PT[4] = '{128'h6bc1bee22e409f96e93d7e117393172a,
                                       128'hae2d8a571e03ac9c9eb76fac45af8e51,
                                       128'h30c81c46a35ce411e5fbc1191a0a52ef,
                                       128'hf69f2445df4f9b17ad2b417be66c3710};
    localparam logic [127:0] CT[4] = '{128'hf3eed1bdb5d2a03c064b5a7e3db181f8,
                                       128'h591ccb10d410ed26dc5ba74a31362870,
                                       128'hb6ed21b99ca6f4f9f153e7b1beafed1d,
                                       128'h23304b7a39f9f3ff067d8d8f9e24ecc7};

    logic         clk = 1'b0;
    logic         reset_n;
    logic         key_valid, key_ready, key_len;
    logic [255:0] key;
    logic         in_valid, in_ready, in_encdec;
    logic [127:0] in_block;
    logic         out_valid, out_ready;
    logic [127:0] out_block;
    logic         cs, we, error;
    logic [7:0]   address;
    logic [31:0]  write_data, read_data;
    logic         key_loaded, err_bus, err_timeout;

    int total = 0, bad = 0;
    int cyc = 0, bus_cycles = 0, s_polls = 0, init_cnt = 0, next_cnt = 0, acc_cyc = 0;
    int ready_after = 3;
    bit never_ready = 1'b0, err_inject = 1'b0;
    logic [31:0]  s_key[8];
    logic [31:0]  s_blk[4];
    logic [1:0]   s_cfg;
    logic [127:0] s_res;
    logic [127:0] rd_sh;
    logic         st_ready;
    logic [127:0] exp_q[$];

    aes_stream_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .key_valid(key_valid), .key_ready(key_ready), .key(key), .key_len(key_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block), .in_encdec(in_encdec),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .cs(cs), .we(we), .address(address), .write_data(write_data), .read_data(read_data),
        .error(error), .key_loaded(key_loaded), .err_bus(err_bus), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] lookup(input logic [255:0] k, input logic [127:0] b,
                                            input logic [1:0] cfg);
        logic [127:0] r;
        r = '0;
        if (k === KEY && cfg[1] === 1'b1)
            for (int i = 0; i < 4; i++) begin
                if (cfg[0] && b === PT[i]) r = CT[i];
                if (!cfg[0] && b === CT[i]) r = PT[i];
            end
        return r;
    endfunction

    // stub core: registers, CTRL side effects, STATUS poll counting
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cs) begin
            bus_cycles <= bus_cycles + 1;
            if (we) begin
                if (address[7:3] == 5'b00010) s_key[address[2:0]] <= write_data;
                else if (address[7:2] == 6'b001000) s_blk[address[1:0]] <= write_data;
                else if (address == 8'h09) s_cfg <= write_data[1:0];
                else if (address == 8'h08) begin
                    s_polls <= 0;
                    if (write_data[0]) init_cnt <= init_cnt + 1;
                    if (write_data[1]) begin
                        next_cnt <= next_cnt + 1;
                        s_res <= lookup({s_key[0], s_key[1], s_key[2], s_key[3],
                                         s_key[4], s_key[5], s_key[6], s_key[7]},
                                        {s_blk[0], s_blk[1], s_blk[2], s_blk[3]}, s_cfg);
                    end
                end
            end else if (address == 8'h0a) begin
                s_polls <= s_polls + 1;
            end
        end
    end

    assign st_ready = !never_ready && (s_polls >= ready_after - 1);
    assign error    = err_inject && cs && we && (address == 8'h21);

    always_comb begin
        rd_sh     = s_res << {address[1:0], 5'b0};
        read_data = 32'h0;
        if (cs && !we) begin
            if (address == 8'h0a) read_data = {31'b0, st_ready};
            else if (address[7:2] == 6'b001100) read_data = rd_sh[127:96];
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_key(input string tag, output int lat);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (key_ready) break;
        end
        check({tag, "_key_ready"}, 128'(key_ready), 128'(1));
        key = KEY; key_len = 1'b1; key_valid = 1'b1;
        @(posedge clk); #1 key_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            lat++;
            if (key_ready) break;
        end
    endtask

    task automatic send_block(input string tag, input logic [127:0] b, input logic enc,
                              input logic [127:0] exp, input bit push);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        if (push) exp_q.push_back(exp);
        in_block = b; in_encdec = enc; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic get_result(input string tag, input bit chk_lat);
        logic [127:0] e;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check({tag, "_valid"}, 128'(out_valid), 128'(1));
        if (out_valid) begin
            if (chk_lat) check({tag, "_latency"}, 128'(cyc - acc_cyc), 128'(16));
            e = '1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            check(tag, out_block, e);
            out_ready = 1'b1;
            @(posedge clk); #1 out_ready = 1'b0;
            check({tag, "_drop"}, 128'(out_valid), 128'(0));
        end
    endtask

    initial begin
        int lat, b0, cnt_bad;
        bit seen;
        logic [127:0] snap;
        reset_n = 1'b0; key_valid = 1'b0; key = '0; key_len = 1'b0;
        in_valid = 1'b0; in_block = '0; in_encdec = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bus", {cs, we, address, write_data}, '0);
        check("rst_hs", {key_ready, in_ready, out_valid}, '0);
        check("rst_flags", {key_loaded, err_bus, err_timeout}, '0);
        check("rst_out_block", out_block, '0);
        @(negedge clk) reset_n = 1'b1;

        // block offered with no key loaded
        in_block = CT[0]; in_valid = 1'b1; b0 = bus_cycles; seen = 1'b0;
        repeat (10) begin @(negedge clk); if (in_ready) seen = 1'b1; end
        in_valid = 1'b0;
        check("t4_no_key_in_ready", 128'(seen), 128'(0));
        check("t4_no_key_bus", 128'(bus_cycles - b0), 128'(0));
        check("t4_idle_key_ready", 128'(key_ready), 128'(1));

        load_key("t1", lat);
        check("t1_key_latency", 128'(lat), 128'(15));
        check("t1_key_loaded", 128'(key_loaded), 128'(1));
        check("t1_init_count", 128'(init_cnt), 128'(1));
        send_block("t1", CT[0], 1'b0, PT[0], 1'b1);
        get_result("t1_dec", 1'b1);

        send_block("t2", PT[1], 1'b1, CT[1], 1'b1);
        get_result("t2_enc", 1'b1);
        for (int i = 0; i < 4; i++) begin
            send_block("t2_b2b", CT[i], 1'b0, PT[i], 1'b1);
            get_result($sformatf("t2_dec%0d", i), 1'b0);
        end
        check("t2_no_reinit", 128'(init_cnt), 128'(1));
        check("t2_next_count", 128'(next_cnt), 128'(6));

        // result held while the consumer stalls
        send_block("t3", CT[2], 1'b0, PT[2], 1'b1);
        for (int n = 0; n < 200; n++) begin @(negedge clk); if (out_valid) break; end
        snap = out_block; b0 = bus_cycles; cnt_bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!out_valid || out_block !== snap || in_ready || cs) cnt_bad++;
        end
        check("t3_stable", 128'(cnt_bad), 128'(0));
        check("t3_bus_idle", 128'(bus_cycles - b0), 128'(0));
        get_result("t3_dec", 1'b0);

        // key and block offered together: key wins
        for (int n = 0; n < 100; n++) begin @(negedge clk); if (key_ready) break; end
        key = KEY; key_len = 1'b1; key_valid = 1'b1; in_block = CT[3]; in_valid = 1'b1;
        b0 = next_cnt;
        #1 check("t4_both_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1 key_valid = 1'b0; in_valid = 1'b0;
        check("t4_both_key_taken", 128'(key_loaded), 128'(0));
        check("t4_both_first_write", 128'({cs, we, address}), 128'({1'b1, 1'b1, 8'h10}));
        for (int n = 0; n < 100; n++) begin @(negedge clk); if (key_ready) break; end
        check("t4_both_reloaded", 128'(key_loaded), 128'(1));
        check("t4_both_no_block", 128'(next_cnt - b0), 128'(0));

        // poll timeout
        never_ready = 1'b1;
        load_key("t5_tmo", lat);
        check("t5_err_timeout", 128'(err_timeout), 128'(1));
        check("t5_tmo_key_loaded", 128'(key_loaded), 128'(0));
        check("t5_tmo_idle", 128'(key_ready), 128'(1));
        check("t5_tmo_polls", 128'(s_polls), 128'(TMO));
        never_ready = 1'b0;
        load_key("t5_reload", lat);
        check("t5_tmo_cleared", 128'(err_timeout), 128'(0));
        check("t5_reload_loaded", 128'(key_loaded), 128'(1));

        // bus error during the second block write
        err_inject = 1'b1; b0 = bus_cycles; seen = 1'b0;
        send_block("t5_err", CT[0], 1'b0, '0, 1'b0);
        repeat (60) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        err_inject = 1'b0;
        check("t5_err_bus", 128'(err_bus), 128'(1));
        check("t5_err_key_loaded", 128'(key_loaded), 128'(0));
        check("t5_err_no_out", 128'(seen), 128'(0));
        check("t5_err_bus_cycles", 128'(bus_cycles - b0), 128'(2));
        check("t5_err_idle", 128'(key_ready), 128'(1));

        // reset in the middle of the result reads
        load_key("t6", lat);
        check("t6_err_bus_cleared", 128'(err_bus), 128'(0));
        send_block("t6", CT[1], 1'b0, PT[1], 1'b1);
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cs && !we && address == 8'h31) begin seen = 1'b1; break; end
        end
        check("t6_reached_res_rd", 128'(seen), 128'(1));
        reset_n = 1'b0;
        #1;
        check("t6_rst_bus", {cs, we, address, write_data}, '0);
        check("t6_rst_hs", {key_ready, in_ready, out_valid, key_loaded}, '0);
        check("t6_rst_out_block", out_block, '0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        load_key("t6_reload", lat);
        check("t6_reload_latency", 128'(lat), 128'(15));
        send_block("t6_t1", CT[0], 1'b0, PT[0], 1'b1);
        get_result("t6_t1_dec", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
